fifo_burst_drainer: RTL

Controller that drains a first-word-fall-through (FWFT) FIFO into Avalon-MM burst writes. Software or an upstream sequencer supplies a base address and word count. The block waits until the FIFO holds a full burst, issues the burst, advances the address, and repeats until the count is exhausted. It is the only reader of its FIFO and sits between the FIFO's read side and the memory-mapped interconnect.

---
 rtl/fifo_burst_drainer_pkg.sv | 35 +++
 rtl/fifo_burst_drainer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drainer_pkg.sv
// Shared definitions for the FWFT-FIFO to Avalon-MM burst drainer: state
// encodings, default geometry and the helpers that derive widths from it.
package fifo_burst_drainer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        DONE      = 2'd3
    } drainer_state_e;

    // Ceiling log2 as a plain loop so it elaborates identically everywhere.
    function automatic int clog2_int(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int burstcount_width(input int burst_len);
        return clog2_int(burst_len) + 1;
    endfunction

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_BURST_LEN    = 16;
    localparam int BYTES_PER_WORD   = bytes_per_word(DEF_DATA_WIDTH);
    localparam int BURSTCOUNT_WIDTH = burstcount_width(DEF_BURST_LEN);

endpackage

// File: rtl/fifo_burst_drainer.sv
// Drains a first-word-fall-through FIFO into Avalon-MM burst writes, one full
// burst at a time, advancing the byte address until the word count is spent.
module fifo_burst_drainer
    import fifo_burst_drainer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int USED_WIDTH = 10,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [LEN_WIDTH-1:0]          total_words,
    output logic                          busy,
    output logic                          done,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
    input  logic [USED_WIDTH-1:0]         fifo_used_w,
    output logic                          fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]         avm_address,
    output logic                          avm_write,
    output logic [DATA_WIDTH-1:0]         avm_writedata,
    output logic [$clog2(BURST_LEN):0]    avm_burstcount,
    output logic [DATA_WIDTH/8-1:0]       avm_byteenable,
    input  logic                          avm_waitrequest
);

    localparam int BPW        = bytes_per_word(DATA_WIDTH);
    localparam int BCW        = burstcount_width(BURST_LEN);
    localparam int ALIGN_BITS = clog2_int(BPW);
    localparam int CMP_W      = (USED_WIDTH > BCW) ? USED_WIDTH : BCW;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(BPW);

    drainer_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remain_q, remain_d;
    logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   avm_address_q, avm_address_d;
    logic [BCW-1:0]          avm_burstcount_q, avm_burstcount_d;
    logic                    avm_write_q, avm_write_d;

    logic [BCW-1:0]          burst_words;
    logic                    data_ready;
    logic                    beat_accept;
    logic                    last_beat;

    // Tail bursts shrink to whatever is left of the transfer.
    always_comb begin
        burst_words = BCW'(BURST_LEN);
        if (remain_q < LEN_WIDTH'(BURST_LEN)) begin
            burst_words = BCW'(remain_q);
        end
    end

    assign data_ready  = CMP_W'(fifo_used_w) >= CMP_W'(burst_words);
    assign beat_accept = avm_write_q & ~avm_waitrequest;
    assign last_beat   = beat_accept && (beat_cnt_q == BCW'(1));

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remain_d         = remain_q;
        beat_cnt_d       = beat_cnt_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        avm_write_d      = avm_write_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (total_words != '0) begin
                        addr_d   = base_addr & ALIGN_MASK;
                        remain_d = total_words;
                        state_d  = WAIT_DATA;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            WAIT_DATA: begin
                // Only commit to a burst once every beat is already in the FIFO.
                if (data_ready) begin
                    avm_address_d    = addr_q;
                    avm_burstcount_d = burst_words;
                    beat_cnt_d       = burst_words;
                    avm_write_d      = 1'b1;
                    state_d          = BURST;
                end
            end

            BURST: begin
                if (beat_accept) begin
                    beat_cnt_d = beat_cnt_q - BCW'(1);
                end
                if (last_beat) begin
                    avm_write_d = 1'b0;
                    addr_d      = addr_q + ADDR_WIDTH'(avm_burstcount_q) * WORD_BYTES;
                    remain_d    = remain_q - LEN_WIDTH'(avm_burstcount_q);
                    if (remain_q == LEN_WIDTH'(avm_burstcount_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remain_q         <= '0;
            beat_cnt_q       <= '0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
            avm_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remain_q         <= remain_d;
            beat_cnt_q       <= beat_cnt_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            avm_write_q      <= avm_write_d;
        end
    end

    // The FIFO pops on exactly the edge the slave takes the beat.
    assign fifo_rd_en     = beat_accept;
    assign avm_writedata  = fifo_rd_data;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = '1;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule
